des3_iter_core: RTL
===================

DES3_ITER_CORE -- requirements
Module: des3_iter_core

Parameters
REQ-001 The block SHALL have parameter NUM_KEYS, default 3, meaning 3 = three independent keys and 2 = two-key keying with K3 taken as K1 (all other values illegal).

Interface
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a block and its keys are offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the core can accept a block.
REQ-006 The block SHALL have port decrypt, input, 1 bit: 0 = EDE encrypt, 1 = DED decrypt; sampled at acceptance.
REQ-007 The block SHALL have port data_in, input, [1:64]: plaintext or ciphertext, bit 1 = MSB (FIPS 46-3 numbering).
REQ-008 The block SHALL have ports key1, key2 and key3, input, [1:64] each: DES keys with parity bits 8,16,...,64 ignored; key3 ignored when NUM_KEYS=2.
REQ-009 The block SHALL have port out_valid, output, 1 bit: data_out holds a finished result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port data_out, output, [1:64]: the result, bit 1 = MSB.
REQ-012 The block SHALL have port busy, output, 1 bit: high in RUN.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE and out_valid SHALL be 1 only in DONE.
REQ-014 In IDLE, in_valid=1 SHALL accept the block: latch IP(data_in) into L/R, latch decrypt, key1, key2 and effective key3, clear round counter rnd[5:0], and go to RUN.
REQ-015 RUN SHALL execute exactly one DES Feistel round per cycle for rnd = 0..47: L'=R, R'=L xor f(R,Kn); rnd 0-15 = stage 1, 16-31 = stage 2, 32-47 = stage 3.
REQ-016 The stage keys and directions SHALL be: encrypt E(K1), D(K2), E(K3); decrypt D(K3), E(K2), D(K1).
REQ-017 Subkeys SHALL be generated on the fly from PC-1/PC-2, one round per cycle: encrypt stages left-rotate C/D by the FIPS shift schedule before use; decrypt stages use the unrotated C/D for round 1, then right-rotate by the reversed schedule.
REQ-018 At each stage boundary (after rnd 15 and rnd 31), the halves SHALL be swapped and the next stage's C/D reloaded from PC-1 of its key, with no FP/IP applied (they cancel).
REQ-019 After rnd 47, the core SHALL apply the final swap and FP, register the result in data_out, and enter DONE.
REQ-020 Latency SHALL be 49 clk edges from the accepting edge to the edge where out_valid rises; throughput SHALL be one block per at least 50 cycles.
REQ-021 In DONE, data_out and out_valid SHALL stay stable until out_ready=1; on that edge the core SHALL go to IDLE, drop out_valid, and raise in_ready.
REQ-022 Input ports SHALL be ignored outside IDLE; changes to data_in, key1-3 or decrypt during RUN/DONE SHALL NOT affect the result.
REQ-023 out_ready=1 outside DONE SHALL have no effect; in_valid and out_ready both high in DONE SHALL complete only the output handshake.
REQ-024 The f-function SHALL be E expansion, XOR with the 48-bit subkey, S1-S8, and P permutation per FIPS 46-3.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, in_ready=1 (after release), out_valid=0, busy=0, data_out=0, rnd=0, and clear all key/data registers, including mid-RUN or mid-DONE; the interrupted block SHALL be discarded.
REQ-026 After rst_n rises, the first rising clk edge with in_valid=1 SHALL be a legal acceptance.

Verification
REQ-027 The bench SHALL check single-DES equivalence: key1=key2=key3=133457799BBCDFF1, data_in=0123456789ABCDEF, decrypt=0 -> data_out=85E813540F0AB405, 49 edges after acceptance.
REQ-028 The bench SHALL check the decrypt equivalent: same keys, data_in=85E813540F0AB405, decrypt=1 -> data_out=0123456789ABCDEF.
REQ-029 The bench SHALL check two-key round trip with NUM_KEYS=2: key1=133457799BBCDFF1, key2=ECCBA8866443200E, key3=random, P=0123456789ABCDEF encrypted then decrypted -> P recovered; result independent of key3.
REQ-030 The bench SHALL check backpressure: out_ready held 0 for 10 cycles after out_valid -> data_out stable and in_ready=0 throughout; out_ready=1 -> in_ready=1 on the next cycle.
REQ-031 The bench SHALL check reset mid-operation: rst_n pulsed low at rnd=20 -> out_valid=0, busy=0, in_ready=1 after release, and a fresh block then produces the correct result.
REQ-032 The bench SHALL check input isolation: data_in and keys randomised every cycle during RUN -> result equals that of the block latched at acceptance.

Source files
------------

// File: rtl/des3_iter_core.sv
// rtl/des3_iter_core.sv - iterative triple-DES core (EDE encrypt / DED decrypt)
// One Feistel round per clock; 48 rounds plus a final FP cycle per block.
module des3_iter_core #(
  parameter int NUM_KEYS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        decrypt,
  input  logic [1:64] data_in,
  input  logic [1:64] key1,
  input  logic [1:64] key2,
  input  logic [1:64] key3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:64] data_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  // Bit p set where the key schedule shifts by two in round p+1.
  localparam logic [0:15] SHIFT_TWO = 16'b0011_1111_0111_1110;

  // One hex digit per entry, indexed by {row, col} from the MSB end.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [1:64] ip_perm(input logic [1:64] d);
    logic [1:64] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[i+1] = d[IP_T[i]];
    return o;
  endfunction

  function automatic logic [1:64] fp_perm(input logic [1:64] d);
    logic [1:64] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[i+1] = d[FP_T[i]];
    return o;
  endfunction

  function automatic logic [1:56] pc1(input logic [1:64] k);
    logic [1:56] o;
    o = '0;
    for (int i = 0; i < 56; i++) o[i+1] = k[PC1_T[i]];
    return o;
  endfunction

  function automatic logic [1:48] pc2(input logic [1:56] cd);
    logic [1:48] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[i+1] = cd[PC2_T[i]];
    return o;
  endfunction

  function automatic logic [1:32] f_func(input logic [1:32] r, input logic [1:48] k);
    logic [1:48] x;
    logic [1:32] s_out;
    logic [1:32] o;
    logic [5:0]  idx;
    x = '0;
    s_out = '0;
    o = '0;
    for (int i = 0; i < 48; i++) x[i+1] = r[E_T[i]] ^ k[i+1];
    for (int s = 0; s < 8; s++) begin
      idx = {x[6*s+1], x[6*s+6], x[6*s+2 +: 4]};
      s_out[4*s+1 +: 4] = SBOX[s][255 - 4*idx -: 4];
    end
    for (int i = 0; i < 32; i++) o[i+1] = s_out[P_T[i]];
    return o;
  endfunction

  // C and D halves rotate independently, by one or two places.
  function automatic logic [1:56] rot_cd(input logic [1:56] cd, input logic left, input logic two);
    logic [1:28] c;
    logic [1:28] d;
    c = cd[1:28];
    d = cd[29:56];
    case ({left, two})
      2'b11:   begin c = {c[3:28], c[1:2]};  d = {d[3:28], d[1:2]};  end
      2'b10:   begin c = {c[2:28], c[1]};    d = {d[2:28], d[1]};    end
      2'b01:   begin c = {c[27:28], c[1:26]}; d = {d[27:28], d[1:26]}; end
      default: begin c = {c[28], c[1:27]};   d = {d[28], d[1:27]};   end
    endcase
    return {c, d};
  endfunction

  state_t       state_q;
  state_t       state_d;
  logic [5:0]   rnd_q;
  logic [1:32]  l_q;
  logic [1:32]  r_q;
  logic [1:56]  cd_q;
  logic [1:56]  ks1_q;
  logic [1:56]  ks2_q;
  logic [1:56]  ks3_q;
  logic         dec_q;

  logic [1:64]  key3_eff;
  logic [1:64]  ip_v;
  logic [1:2]   stage;
  logic [3:0]   pos;
  logic [3:0]   mpos;
  logic         stage_dec;
  logic         two;
  logic [1:56]  cd_rot;
  logic [1:48]  subkey;
  logic [1:32]  f_out;
  logic [1:56]  next_cd;
  logic         last_step;
  logic         stage_end;

  assign key3_eff  = (NUM_KEYS == 2) ? key1 : key3;
  assign ip_v      = ip_perm(data_in);
  assign stage     = rnd_q[5:4];
  assign pos       = rnd_q[3:0];
  assign mpos      = 4'd0 - pos;
  assign last_step = (rnd_q == 6'd48);
  assign stage_end = (pos == 4'd15) && (stage != 2'd2);

  // The middle stage runs in the opposite direction to the outer two.
  assign stage_dec = dec_q ^ (stage == 2'd1);
  assign two       = stage_dec ? SHIFT_TWO[mpos] : SHIFT_TWO[pos];
  assign cd_rot    = (stage_dec && (pos == 4'd0)) ? cd_q : rot_cd(cd_q, !stage_dec, two);
  assign subkey    = pc2(cd_rot);
  assign f_out     = f_func(r_q, subkey);
  assign next_cd   = (stage == 2'd0) ? ks2_q : (dec_q ? ks1_q : ks3_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_q    <= '0;
      l_q      <= '0;
      r_q      <= '0;
      cd_q     <= '0;
      ks1_q    <= '0;
      ks2_q    <= '0;
      ks3_q    <= '0;
      dec_q    <= 1'b0;
      data_out <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            l_q   <= ip_v[1:32];
            r_q   <= ip_v[33:64];
            dec_q <= decrypt;
            ks1_q <= pc1(key1);
            ks2_q <= pc1(key2);
            ks3_q <= pc1(key3_eff);
            cd_q  <= decrypt ? pc1(key3_eff) : pc1(key1);
            rnd_q <= '0;
          end
        end
        RUN: begin
          if (last_step) begin
            data_out <= fp_perm({r_q, l_q});
          end else begin
            rnd_q <= rnd_q + 6'd1;
            // Between stages FP/IP cancel, leaving only the output swap.
            if (stage_end) begin
              l_q  <= l_q ^ f_out;
              r_q  <= r_q;
              cd_q <= next_cd;
            end else begin
              l_q  <= r_q;
              r_q  <= l_q ^ f_out;
              cd_q <= cd_rot;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
